// File: rtl/led_panel_pkg.sv
// led_panel_pkg
//   Shared geometry constants, FSM state encoding and the stripe colour
//   helper for the HUB75 LED panel driver.
//   Panel: 32 columns x 16 rows, 1/8 scan (two halves shifted in parallel).
package led_panel_pkg;

  localparam int COLS         = 32;
  localparam int ROWS         = 16;
  localparam int SCAN_ROWS    = 8;
  localparam int SHIFT_CYCLES = 64;  // two clk cycles per column

  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    BLANK   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  // Diagonal stripe colour index: (x + y + phase) mod 8, bits map to {R,G,B}.
  function automatic logic [2:0] stripe_value(
    input logic [4:0] x,
    input logic [3:0] y,
    input logic [2:0] phase
  );
    stripe_value = 3'(x + 5'(y) + 5'(phase));
  endfunction

endpackage

// File: rtl/led_panel_pattern.sv
// led_panel_pattern
//   Combinational test-pattern generator for one panel pixel.
//   Ports:
//     x     in  5  column 0-31
//     y     in  4  panel row 0-15
//     phase in  3  animation phase
//     rgb   out 3  {R,G,B}
module led_panel_pattern
  import led_panel_pkg::*;
(
  input  logic [4:0] x,
  input  logic [3:0] y,
  input  logic [2:0] phase,
  output logic [2:0] rgb
);

  assign rgb = stripe_value(x, y, phase);

endmodule

// File: rtl/led_panel.sv
// led_panel
//   Self-contained HUB75 driver for a 32x16, 1/8 scan, 1-bit-per-channel
//   panel showing an animated diagonal stripe pattern.
//   Row sequence: SHIFT (64) -> BLANK (1) -> LATCH (1) -> DISPLAY (ON_TIME).
//   Optional build macro LED_PANEL_OVERLAP_EN: keep the previously latched
//   row lit while the next row shifts in (after the first latch).
//   Ports:
//     clk       in  1  system clock, rising edge
//     reset     in  1  synchronous, active-high
//     led_rgb1  out 3  {R,G,B} upper half (rows 0-7)
//     led_rgb2  out 3  {R,G,B} lower half (rows 8-15)
//     led_abc   out 3  row-pair address {C,B,A}
//     led_clk   out 1  panel shift clock
//     led_latch out 1  latch strobe, active high
//     led_oe    out 1  output enable, active low
module led_panel
  import led_panel_pkg::*;
#(
  parameter int UPDATE_CLK = 5000000,
  parameter int ON_TIME    = 256
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] led_rgb1,
  output logic [2:0] led_rgb2,
  output logic [2:0] led_abc,
  output logic       led_clk,
  output logic       led_latch,
  output logic       led_oe
);

  localparam int CNT_MAX = (ON_TIME > SHIFT_CYCLES) ? ON_TIME : SHIFT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int UPD_W   = (UPDATE_CLK > 1) ? $clog2(UPDATE_CLK) : 1;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TIME - 1);
  localparam logic [UPD_W-1:0] UPD_LAST   = UPD_W'(UPDATE_CLK - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        row_r, row_s;
  logic [2:0]        phase_r, phase_s;
  logic [UPD_W-1:0]  upd_cnt_r;
  logic              pending_r, pending_s;
  logic              upd_wrap_s;
  logic              frame_end_s;
  logic [4:0]        col_s;
  logic [2:0]        rgb_top_s, rgb_bot_s;
  logic              shift_oe_s;

  // Columns go out 31 down to 0; each column spans two cycles.
  assign col_s      = ~cnt_r[5:1];
  assign upd_wrap_s = (upd_cnt_r == UPD_LAST);

  led_panel_pattern u_pat_top (
    .x     (col_s),
    .y     ({1'b0, row_r}),
    .phase (phase_r),
    .rgb   (rgb_top_s)
  );

  led_panel_pattern u_pat_bot (
    .x     (col_s),
    .y     ({1'b1, row_r}),
    .phase (phase_r),
    .rgb   (rgb_bot_s)
  );

`ifdef LED_PANEL_OVERLAP_EN
  logic lit_r;

  // Remembers that a row has been latched, so shifting may keep it lit.
  always_ff @(posedge clk) begin
    if (reset) begin
      lit_r <= 1'b0;
    end else if (state_r == LATCH) begin
      lit_r <= 1'b1;
    end else begin
      lit_r <= lit_r;
    end
  end

  assign shift_oe_s = ~lit_r;
`else
  assign shift_oe_s = 1'b1;
`endif

  // Next-state, cycle counter, row and phase advance.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + CNT_W'(1);
    row_s       = row_r;
    phase_s     = phase_r;
    frame_end_s = 1'b0;
    case (state_r)
      SHIFT: begin
        if (cnt_r == SHIFT_LAST) begin
          state_s = BLANK;
          cnt_s   = '0;
        end else begin
          state_s = SHIFT;
        end
      end
      BLANK: begin
        state_s = LATCH;
        cnt_s   = '0;
      end
      LATCH: begin
        state_s = DISPLAY;
        cnt_s   = '0;
      end
      DISPLAY: begin
        if (cnt_r == ON_LAST) begin
          state_s     = SHIFT;
          cnt_s       = '0;
          row_s       = row_r + 3'd1;
          frame_end_s = (row_r == 3'd7);
        end else begin
          state_s = DISPLAY;
        end
      end
      default: begin
        state_s = SHIFT;
        cnt_s   = '0;
      end
    endcase
    // Phase only moves between frames so a frame is never torn.
    if (frame_end_s && pending_r) begin
      phase_s = phase_r + 3'd1;
    end else begin
      phase_s = phase_r;
    end
    pending_s = (pending_r & ~frame_end_s) | upd_wrap_s;
  end

  // FSM, counters and animation state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SHIFT;
      cnt_r     <= '0;
      row_r     <= 3'd0;
      phase_r   <= 3'd0;
      pending_r <= 1'b0;
      upd_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      row_r     <= row_s;
      phase_r   <= phase_s;
      pending_r <= pending_s;
      upd_cnt_r <= upd_wrap_s ? '0 : upd_cnt_r + UPD_W'(1);
    end
  end

  // Registered panel outputs derived from the current state and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_rgb1  <= 3'd0;
      led_rgb2  <= 3'd0;
      led_abc   <= 3'd0;
      led_clk   <= 1'b0;
      led_latch <= 1'b0;
      led_oe    <= 1'b1;
    end else begin
      led_clk   <= 1'b0;
      led_latch <= 1'b0;
      led_oe    <= 1'b1;
      case (state_r)
        SHIFT: begin
          led_clk <= cnt_r[0];
          led_oe  <= shift_oe_s;
          // New data on the low half of each step, held while clk is high.
          if (!cnt_r[0]) begin
            led_rgb1 <= rgb_top_s;
            led_rgb2 <= rgb_bot_s;
          end else begin
            led_rgb1 <= led_rgb1;
            led_rgb2 <= led_rgb2;
          end
        end
        BLANK:   led_abc   <= row_r;
        LATCH:   led_latch <= 1'b1;
        DISPLAY: led_oe    <= 1'b0;
        default: led_oe    <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel.sv
// tb_led_panel
//   Directed self-checking bench for led_panel (UPDATE_CLK=1000 so the
//   animation advances every frame). Outputs sampled on the falling edge.
module tb_led_panel;

  localparam int UPD        = 1000;
  localparam int ON         = 256;
  localparam int ROW_PERIOD = 322;
`ifdef LED_PANEL_OVERLAP_EN
  localparam int OE_RUN = 320;
  localparam bit OVL    = 1'b1;
`else
  localparam int OE_RUN = 256;
  localparam bit OVL    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] led_rgb1, led_rgb2, led_abc;
  logic       led_clk, led_latch, led_oe;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor state
  int cyc, row_exp, frame, k, last_clk_hi, last_latch, oe_run, first_rise, n_latch;
  bit latched;
  logic prev_clk, prev_oe, prev_latch;
  logic [2:0] prev_abc;

  always #5 clk = ~clk;

  led_panel #(.UPDATE_CLK(UPD), .ON_TIME(ON)) dut (
    .clk       (clk),
    .reset     (reset),
    .led_rgb1  (led_rgb1),
    .led_rgb2  (led_rgb2),
    .led_abc   (led_abc),
    .led_clk   (led_clk),
    .led_latch (led_latch),
    .led_oe    (led_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, 32'({led_oe, led_latch, led_clk, led_rgb1, led_rgb2, led_abc}),
          32'({1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0}));
  endtask

  task automatic init_mon();
    cyc = 0; row_exp = 0; frame = 0; k = 0; last_clk_hi = 0; last_latch = -1;
    oe_run = 0; first_rise = -1; n_latch = 0; latched = 1'b0;
    prev_clk = 1'b0; prev_oe = 1'b1; prev_latch = 1'b0; prev_abc = 3'd0;
  endtask

  // One monitored cycle: sample after the falling edge and check events.
  task automatic step();
    logic [2:0] ph, e1, e2;
    @(negedge clk);
    cyc++;
    if (led_clk && !prev_clk) begin
      if (first_rise < 0) begin
        first_rise = cyc;
        check("first_rise_cycle", 32'(cyc), 32'd2);
      end
      ph = frame[2:0];
      e1 = 3'(31 - k + row_exp + 32'(ph));
      e2 = 3'(31 - k + row_exp + 8 + 32'(ph));
      check("shift_rgb1", 32'(led_rgb1), 32'(e1));
      check("shift_rgb2", 32'(led_rgb2), 32'(e2));
      check("shift_oe", 32'(led_oe), (OVL && latched) ? 32'd0 : 32'd1);
      if (frame == 0 && row_exp == 0 && k == 0) begin
        check("first_rgb1", 32'(led_rgb1), 32'd7);
        check("first_rgb2", 32'(led_rgb2), 32'd7);
      end
      if (frame == 1 && row_exp == 0 && k == 0)
        check("phase1_rgb1", 32'(led_rgb1), 32'd0);
      k++;
    end
    if (led_clk) last_clk_hi = cyc;
    if (led_latch) begin
      check("latch_clk_low", 32'(led_clk), 32'd0);
      check("latch_width", 32'(prev_latch), 32'd0);
      check("latch_oe", 32'(led_oe), 32'd1);
      check("latch_rises", 32'(k), 32'd32);
      check("latch_gap_clk", 32'(cyc - last_clk_hi), 32'd2);
      check("latch_abc", 32'(led_abc), 32'(row_exp));
      if (last_latch >= 0) check("latch_period", 32'(cyc - last_latch), 32'(ROW_PERIOD));
      last_latch = cyc; k = 0; latched = 1'b1; n_latch++;
      row_exp = (row_exp + 1) % 8;
      if (row_exp == 0) frame++;
    end
    if (led_abc != prev_abc) check("abc_change_oe", 32'(led_oe), 32'd1);
    if (!led_oe) oe_run++;
    else if (!prev_oe) begin
      check("oe_low_len", 32'(oe_run), 32'(OE_RUN));
      oe_run = 0;
    end
    prev_clk = led_clk; prev_oe = led_oe; prev_latch = led_latch; prev_abc = led_abc;
  endtask

  initial begin
    bit found;
    // reset held for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_reset_outs("reset_hold");
    end
    reset = 1'b0;
    init_mon();
    for (int i = 0; i < 8000; i++) step();
    // latches at cycle 66 + 322*i, i = 0..24
    check("latch_count", 32'(n_latch), 32'd25);

    // reach DISPLAY of row 5, then reset mid-row
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      if (row_exp == 6 && !led_oe && led_abc == 3'd5) found = 1'b1;
    end
    check("reach_row5_display", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_oe", 32'(led_oe), 32'd1);
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      check_reset_outs("reset_mid_hold");
    end
    reset = 1'b0;
    init_mon();
    for (int i = 0; i < 3000; i++) step();
    check("latch_count_restart", 32'(n_latch), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
